// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: coin codes, coin values
// and the sequencing FSM state encoding.
package vending_pkg;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_e;

endpackage

// File: rtl/coin_value_dec.sv
// Combinational coin decoder: coin code to value in cents plus an invalid flag.
// Shared with the coin-acceptor model used in benches.
module coin_value_dec
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [1:0]          coin_code_i,
    output logic [CREDIT_W-1:0] value_o,
    output logic                invalid_o
);

    always_comb begin
        value_o   = '0;
        invalid_o = 1'b0;
        case (coin_code_i)
            COIN_NICKEL:  value_o = CREDIT_W'(VAL_NICKEL);
            COIN_DIME:    value_o = CREDIT_W'(VAL_DIME);
            COIN_QUARTER: value_o = CREDIT_W'(VAL_QUARTER);
            default:      invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vending_ctrl.sv
// Vending sequencer: accumulates coin credit, strobes dispense when the price
// is met, then pays back the remainder one nickel per cycle.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE      = 75,
    parameter int MAX_CREDIT = 100,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy
);

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  reject_q, reject_d;
    logic [CREDIT_W-1:0]   coin_val;
    logic                  coin_inv;
    logic [CREDIT_W:0]     sum;

    coin_value_dec #(.CREDIT_W(CREDIT_W)) u_dec (
        .coin_code_i (coin_code),
        .value_o     (coin_val),
        .invalid_o   (coin_inv)
    );

    // One extra bit so the overflow compare never sees a wrapped sum
    assign sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && (state_q == COLLECT))
                    state_d = CHANGE;
                if (coin_valid) begin
                    // Invalid code, a simultaneous cancel, or overflow all refuse the coin
                    if (coin_inv || cancel || (sum > (CREDIT_W+1)'(MAX_CREDIT))) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= (CREDIT_W+1)'(PRICE)) ? DISPENSE : COLLECT;
                    end
                end
            end
            DISPENSE: begin
                reject_d = coin_valid;
                credit_d = credit_q - CREDIT_W'(PRICE);
                state_d  = (credit_q > CREDIT_W'(PRICE)) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_valid;
                if (credit_q <= CREDIT_W'(VAL_NICKEL)) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(VAL_NICKEL);
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign credit        = credit_q;
    assign dispense      = (state_q == DISPENSE);
    assign change_nickel = (state_q == CHANGE);
    assign busy          = (state_q == DISPENSE) || (state_q == CHANGE);
    assign coin_reject   = reject_q;

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Central sequencing FSM for the digital vending machine. It accepts coin pulses, accumulates credit, fires a single-cycle dispense strobe once the price is met, and returns any remaining credit as a serial stream of nickel pulses. It sits between the coin-acceptor front end and the dispense/change actuators. Its downstream gating logic is the simple combinational gate family already in the design.

Parameters:
PRICE, 75, item price in cents; must be a multiple of 5 and no greater than MAX_CREDIT.
MAX_CREDIT, 100, maximum credit held in cents; must be a multiple of 5.
CREDIT_W, 8, width of the credit register; must satisfy 2^CREDIT_W > MAX_CREDIT + 25.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
coin_valid  input  1  a coin is present this cycle.
coin_code  input  2  coin type: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 invalid.
cancel  input  1  request to refund all credit.
credit  output  CREDIT_W  current credit in cents (registered).
dispense  output  1  one-cycle dispense strobe.
change_nickel  output  1  one pulse per 5 cents returned.
coin_reject  output  1  one-cycle pulse when an offered coin is refused.
busy  output  1  high in DISPENSE and CHANGE.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- On reset: state IDLE, credit = 0, and dispense, change_nickel, coin_reject and busy all 0. Reset overrides everything, including mid-DISPENSE and mid-CHANGE; credit pending refund is discarded.
- States:
  - IDLE: credit = 0.
  - COLLECT: 0 < credit < PRICE.
  - DISPENSE: lasts exactly 1 cycle.
  - CHANGE: refund in progress.
- dispense = (state == DISPENSE), Moore-decoded.
- change_nickel = (state == CHANGE), Moore-decoded.
- busy = DISPENSE or CHANGE.
- coin_reject is registered and asserted in the cycle after the refusing edge.
- Coin evaluation applies in IDLE/COLLECT when coin_valid = 1 at edge N. Checks are taken in this order:
  1. coin_code == 11 -> reject; credit unchanged.
  2. cancel == 1 as well -> cancel wins; coin rejected.
  3. credit + value > MAX_CREDIT -> reject; credit unchanged.
  4. Otherwise credit <= credit + value at edge N, visible after edge N.
- Transitions after an accepted coin: new credit >= PRICE -> DISPENSE; else COLLECT.
- coin_valid in DISPENSE or CHANGE -> coin_reject; credit unchanged.
- DISPENSE: at exit edge, credit <= credit - PRICE. Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE: each edge, credit <= credit - 5. When credit == 5 at the edge, the next state is IDLE (credit becomes 0). Number of change_nickel pulses = refund / 5, on consecutive cycles.
- cancel in COLLECT -> CHANGE; full credit is refunded.
- cancel in IDLE, DISPENSE or CHANGE is ignored.
- Arithmetic: unsigned, CREDIT_W bits. Credit is always a multiple of 5. The sum is computed CREDIT_W+1 wide before the overflow compare, so there is no wrap.
- Latency: coin edge to dispense high is 1 cycle. Dispense to first change pulse is 1 cycle.

Decomposition:
- Package vending_pkg holds:
  - coin code localparams (COIN_NICKEL, COIN_DIME, COIN_QUARTER, COIN_INVALID);
  - coin value constants 5/10/25;
  - the state encoding (IDLE, COLLECT, DISPENSE, CHANGE).
- One sub-module: coin_value_dec. It is combinational, maps coin_code to value (CREDIT_W bits) and an invalid flag, and is reused by the coin-acceptor model in benches.

Test Plan:
1. Three quarters on consecutive cycles (default params) -> credit 25, 50, 75; dispense high for exactly 1 cycle after the third coin; no change_nickel pulses; returns to IDLE with credit 0.
2. Eight dimes -> credit reaches 80; dispense for 1 cycle; then exactly 1 change_nickel pulse; then IDLE with credit 0.
3. Quarter, dime, then cancel -> credit 35; 7 consecutive change_nickel pulses with credit stepping 30 down to 0; dispense never asserted.
4. coin_code = 11 with coin_valid, and separately a dime during a CHANGE sequence -> coin_reject 1 cycle each; credit unchanged; the refund count is unaffected.
5. PRICE = 95, MAX_CREDIT = 100: build credit to 90, then a quarter -> coin_reject because 115 > 100; credit stays 90. Then a nickel -> dispense; no change.
6. rst asserted during the 3rd pulse of a 7-pulse refund -> next cycle state is IDLE; credit, change_nickel and busy are all 0; a subsequent nickel is accepted (credit 5).
